// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/issue sequencer.
//   - default widths and the imem wait limit
//   - FSM state encoding
//   - branch-select encoding used by the next-pc calculator
package fetch_pkg;

  localparam int PC_W_DEF     = 8;
  localparam int INSTR_W_DEF  = 9;
  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    BR_SEQ = 2'b00,  // fall through to pc+1
    BR_FWD = 2'b01,  // pc+1+target
    BR_BWD = 2'b10   // pc+1-target
  } br_sel_t;

  // Forward branch wins when both flags are raised.
  function automatic br_sel_t br_select(input logic branchf, input logic branchb);
    if (branchf) begin
      return BR_FWD;
    end else if (branchb) begin
      return BR_BWD;
    end
    return BR_SEQ;
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// Combinational next program counter after a completed instruction.
// Ports:
//   pc       in   current program counter
//   branchf  in   forward branch taken
//   branchb  in   backward branch taken
//   target   in   unsigned branch offset
//   next_pc  out  pc+1, pc+1+target or pc+1-target (modulo 2^PC_W)
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic            branchf,
  input  logic            branchb,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc_inc;
  br_sel_t         sel;

  assign pc_inc = pc + PC_W'(1);
  assign sel    = br_select(branchf, branchb);

  // All sums are PC_W bits wide so they wrap silently.
  always_comb begin
    next_pc = pc_inc;
    case (sel)
      BR_FWD:  next_pc = pc_inc + target;
      BR_BWD:  next_pc = pc_inc - target;
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue controller owning the program counter of the single-issue core.
// Fetches from imem over req/ack, issues to execute over valid/ready, then
// applies the branch/halt outcome reported on ex_done_i.
// Ports:
//   clk_i, rstn_i                  clock, async active-low reset
//   start_i, startadd_i            (re)start fetching at startadd_i, any state
//   imem_req_o, imem_addr_o        fetch request / address (= pc_o)
//   imem_ack_i, imem_data_i        fetch response
//   instr_valid_o, instr_o         issued instruction (registered)
//   instr_ready_i                  execute accepts instr_o
//   ex_done_i, branchf_i, branchb_i, target_i, halt_i   completion info
//   pc_o, busy_o, halted_o, timeout_o                   status
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic [PC_W-1:0]    startadd_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  input  logic               instr_ready_i,
  input  logic               ex_done_i,
  input  logic               branchf_i,
  input  logic               branchb_i,
  input  logic [PC_W-1:0]    target_i,
  input  logic               halt_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               busy_o,
  output logic               halted_o,
  output logic               timeout_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t             state, state_next;
  logic [PC_W-1:0]    pc, pc_next;
  logic [INSTR_W-1:0] instr, instr_next;
  logic [WAIT_W-1:0]  wait_cnt, wait_next;
  logic [PC_W-1:0]    pc_calc;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
    .pc      (pc),
    .branchf (branchf_i),
    .branchb (branchb_i),
    .target  (target_i),
    .next_pc (pc_calc)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_IDLE;
      pc       <= '0;
      instr    <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      instr    <= instr_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
    wait_next  = wait_cnt;
    if (start_i) begin
      // Restart from anywhere; whatever was in flight is simply dropped.
      pc_next    = startadd_i;
      wait_next  = '0;
      state_next = ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          // An ack in the final allowed wait cycle still counts.
          if (imem_ack_i) begin
            instr_next = imem_data_i;
            wait_next  = '0;
            state_next = ST_ISSUE;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            state_next = ST_ERR;
          end else begin
            wait_next = wait_cnt + WAIT_W'(1);
          end
        end
        ST_ISSUE: begin
          if (instr_ready_i) begin
            state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (ex_done_i) begin
            if (halt_i) begin
              state_next = ST_HALTED;
            end else begin
              pc_next    = pc_calc;
              state_next = ST_FETCH;
            end
          end
        end
        default: begin
          // IDLE, HALTED and ERR only leave on start_i.
          state_next = state;
        end
      endcase
    end
  end

  assign imem_req_o    = (state == ST_FETCH);
  assign imem_addr_o   = pc;
  assign instr_valid_o = (state == ST_ISSUE);
  assign instr_o       = instr;
  assign pc_o          = pc;
  assign busy_o        = (state == ST_FETCH) || (state == ST_ISSUE) || (state == ST_EXEC);
  assign halted_o      = (state == ST_HALTED);
  assign timeout_o     = (state == ST_ERR);

endmodule
